pcs_rx_sync_1000x: RTL and testbench
====================================

Name: pcs_rx_sync_1000x

Overview:
- IEEE 802.3 clause 36 receive synchronisation state machine (Figure 36-9) for 1000BASE-X.
- Sits directly downstream of the GTX 1000BASE-X transceiver wrapper and consumes its decoded 8-bit code-group stream.
- Drives the wrapper's comma-align enables and produces SYNC_STATUS, RX_EVEN and a 1-cycle-delayed code-group stream for the PCS receive state machine.

Parameters:
- ACQUIRE_COMMAS, 3, consecutive validly-spaced commas needed to reach sync.
- RECOVER_GOOD, 4, consecutive good code-groups that cancel one accumulated bad.
- LOSE_BAD, 4, accumulated bads (uncancelled) that drop sync.
- LOS_CNT_WIDTH, 16, width of the loss-of-sync event counter.

Ports:
- RXUSRCLK2  in  1  clock; one code-group per cycle.
- RXRESET  in  1  synchronous, active-high reset.
- RESETDONE  in  1  GTX reset complete.
- RXELECIDLE  in  1  GTX electrical idle.
- RXBUFERR  in  1  GTX elastic buffer error.
- RXDATA  in  8  decoded code-group.
- RXCHARISK  in  1  K-character flag.
- RXCHARISCOMMA  in  1  comma flag.
- RXDISPERR  in  1  disparity error.
- RXNOTINTABLE  in  1  invalid code.
- ENPCOMMAALIGN  out  1  to GTX.
- ENMCOMMAALIGN  out  1  to GTX.
- SYNC_STATUS  out  1  1 = OK.
- RX_EVEN  out  1  parity of the current output code-group.
- RXDATA_OUT  out  8  registered RXDATA.
- RXCHARISK_OUT  out  1  registered RXCHARISK.
- RXERR_OUT  out  1  registered (RXDISPERR | RXNOTINTABLE).
- LOS_COUNT  out  LOS_CNT_WIDTH  saturating count of sync-lost events.

Behaviour:
- Definitions:
  - signal_detect = RESETDONE & ~RXELECIDLE.
  - invalid = RXDISPERR | RXNOTINTABLE.
  - cgbad = invalid | (RXCHARISCOMMA & rx_even).
  - cggood = ~cgbad.
  - rx_even is internal and means "previous code-group was even".
  - data = ~RXCHARISK & ~invalid.
- All state, counters and outputs update on the RXUSRCLK2 rising edge. One code-group is evaluated per cycle.
- Reset (RXRESET=1) values:
  - state = LOSS_OF_SYNC, rx_even = 0.
  - SYNC_STATUS = 0, ENPCOMMAALIGN = ENMCOMMAALIGN = 1.
  - RX_EVEN = 0, RXDATA_OUT = 8'h00, RXCHARISK_OUT = 0, RXERR_OUT = 0, LOS_COUNT = 0.
  - Reset asserted mid-operation behaves identically; LOS_COUNT is not incremented by reset.
- Global override: signal_detect=0 or RXBUFERR=1 in any state forces next state LOSS_OF_SYNC and rx_even <= 0. This has priority over every other transition.
- States:
  - LOSS_OF_SYNC:
    - rx_even toggles each cycle.
    - On signal_detect & RXCHARISCOMMA: go to COMMA_DETECT, set comma_cnt = 1, rx_even <= 1.
  - COMMA_DETECT:
    - rx_even <= 0.
    - If data: go to ACQUIRE_SYNC. Otherwise go to LOSS_OF_SYNC.
    - If data and comma_cnt == ACQUIRE_COMMAS: go to SYNC_ACQUIRED instead of ACQUIRE_SYNC, with bad_cnt = 0 and good_cgs = 0.
  - ACQUIRE_SYNC:
    - rx_even toggles.
    - cgbad: go to LOSS_OF_SYNC.
    - cggood & RXCHARISCOMMA: go to COMMA_DETECT, comma_cnt++, rx_even <= 1.
    - Otherwise stay.
  - SYNC_ACQUIRED:
    - rx_even toggles, except that a cggood comma sets rx_even <= 1.
    - cgbad: bad_cnt++, good_cgs <= 0.
      - If bad_cnt reaches LOSE_BAD: go to LOSS_OF_SYNC and increment LOS_COUNT (saturates at all-ones).
    - cggood with bad_cnt > 0: good_cgs++.
      - When good_cgs reaches RECOVER_GOOD: bad_cnt--, good_cgs <= 0.
    - cggood with bad_cnt == 0: good_cgs stays 0.
    - cgbad exactly on the cycle good_cgs would reach RECOVER_GOOD counts as bad; no decrement occurs.
- Outputs:
  - SYNC_STATUS = 1 iff state is SYNC_ACQUIRED. It is registered, so it rises the cycle after the final data code-group of acquisition.
  - ENPCOMMAALIGN = ENMCOMMAALIGN = 1 iff state is LOSS_OF_SYNC.
  - RX_EVEN, RXDATA_OUT, RXCHARISK_OUT and RXERR_OUT have 1-cycle latency and are mutually aligned.
  - RX_EVEN = 1 marks the code-group presented on RXDATA_OUT as even.
- Widths:
  - comma_cnt is 2 bits; ACQUIRE_COMMAS <= 3.
  - bad_cnt is 3 bits.
  - good_cgs is 3 bits.

Test Plan:
- Reset, then stream K28.5 (8'hBC, K=1, COMMA=1) and D16.2 (8'h50) alternately:
  - SYNC_STATUS rises on the cycle after the 3rd D16.2.
  - ENPCOMMAALIGN falls on the cycle after the 1st K28.5.
  - RX_EVEN = 1 with each BC on RXDATA_OUT.
- Sync acquired, then 3 code-groups with RXDISPERR=1 and afterwards continuous good /I2/:
  - SYNC_STATUS stays 1.
  - After 12 good code-groups, internal bad_cnt returns to 0.
- Sync acquired, then 4 consecutive RXNOTINTABLE=1 code-groups:
  - SYNC_STATUS drops 1 cycle after the 4th.
  - LOS_COUNT goes 0 -> 1.
  - Comma-align enables are 1.
- Comma at an odd position (K28.5, K28.5) during ACQUIRE_SYNC: returns to LOSS_OF_SYNC and SYNC_STATUS stays 0.
- Sync acquired, then RXELECIDLE=1 for one cycle:
  - Immediate LOSS_OF_SYNC and LOS_COUNT +1.
  - Re-acquisition after 3 comma/data pairs.
- RXRESET pulsed while in SYNC_ACQUIRED: all outputs return to reset values next cycle and LOS_COUNT = 0.

Source files
------------

// File: rtl/pcs_rx_sync_1000x_if.sv
// Code-group bus between the GTX 1000BASE-X wrapper, the receive sync block
// and the downstream PCS receive state machine.
interface pcs_rx_sync_1000x_if #(
  parameter int LOS_CNT_WIDTH = 16
);
  logic                     RESETDONE;
  logic                     RXELECIDLE;
  logic                     RXBUFERR;
  logic [7:0]               RXDATA;
  logic                     RXCHARISK;
  logic                     RXCHARISCOMMA;
  logic                     RXDISPERR;
  logic                     RXNOTINTABLE;
  logic                     ENPCOMMAALIGN;
  logic                     ENMCOMMAALIGN;
  logic                     SYNC_STATUS;
  logic                     RX_EVEN;
  logic [7:0]               RXDATA_OUT;
  logic                     RXCHARISK_OUT;
  logic                     RXERR_OUT;
  logic [LOS_CNT_WIDTH-1:0] LOS_COUNT;

  modport master (
    output RESETDONE, RXELECIDLE, RXBUFERR, RXDATA, RXCHARISK, RXCHARISCOMMA,
           RXDISPERR, RXNOTINTABLE,
    input  ENPCOMMAALIGN, ENMCOMMAALIGN, SYNC_STATUS, RX_EVEN, RXDATA_OUT,
           RXCHARISK_OUT, RXERR_OUT, LOS_COUNT
  );

  modport slave (
    input  RESETDONE, RXELECIDLE, RXBUFERR, RXDATA, RXCHARISK, RXCHARISCOMMA,
           RXDISPERR, RXNOTINTABLE,
    output ENPCOMMAALIGN, ENMCOMMAALIGN, SYNC_STATUS, RX_EVEN, RXDATA_OUT,
           RXCHARISK_OUT, RXERR_OUT, LOS_COUNT
  );
endinterface

// File: rtl/pcs_rx_sync_1000x.sv
// 1000BASE-X receive synchronisation FSM: acquires comma alignment, tracks
// code-group parity and drops sync after too many uncancelled bad code-groups.
module pcs_rx_sync_1000x #(
  parameter int ACQUIRE_COMMAS = 3,
  parameter int RECOVER_GOOD   = 4,
  parameter int LOSE_BAD       = 4,
  parameter int LOS_CNT_WIDTH  = 16
) (
  input logic                 RXUSRCLK2,
  input logic                 RXRESET,
  pcs_rx_sync_1000x_if.slave  bus
);

  localparam logic [1:0] ACQ_N  = 2'(ACQUIRE_COMMAS);
  localparam logic [2:0] GOOD_N = 3'(RECOVER_GOOD);
  localparam logic [2:0] BAD_N  = 3'(LOSE_BAD);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED
  } state_e;

  state_e                   state_q, state_d;
  logic                     rx_even_q, rx_even_d;
  logic [1:0]               comma_cnt_q, comma_cnt_d;
  logic [2:0]               bad_cnt_q, bad_cnt_d;
  logic [2:0]               good_cgs_q, good_cgs_d;
  logic                     sync_q, align_q;
  logic [7:0]               data_q;
  logic                     k_q, err_q;
  logic [LOS_CNT_WIDTH-1:0] los_q;

  logic       signal_detect, invalid, cgbad, is_data, los_evt;
  logic [2:0] bad_inc;

  always_comb begin
    signal_detect = bus.RESETDONE & ~bus.RXELECIDLE;
    invalid       = bus.RXDISPERR | bus.RXNOTINTABLE;
    // rx_even_q set means the previous code-group was even, so a comma now is misplaced
    cgbad         = invalid | (bus.RXCHARISCOMMA & rx_even_q);
    is_data       = ~bus.RXCHARISK & ~invalid;
    bad_inc       = bad_cnt_q + 3'd1;

    state_d     = state_q;
    rx_even_d   = ~rx_even_q;
    comma_cnt_d = comma_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    good_cgs_d  = good_cgs_q;
    los_evt     = 1'b0;

    if (!signal_detect || bus.RXBUFERR) begin
      state_d   = LOSS_OF_SYNC;
      rx_even_d = 1'b0;
      los_evt   = (state_q == SYNC_ACQUIRED);
    end else begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (bus.RXCHARISCOMMA) begin
            state_d     = COMMA_DETECT;
            comma_cnt_d = 2'd1;
            rx_even_d   = 1'b1;
          end
        end
        COMMA_DETECT: begin
          rx_even_d = 1'b0;
          if (!is_data) begin
            state_d = LOSS_OF_SYNC;
          end else if (comma_cnt_q == ACQ_N) begin
            state_d    = SYNC_ACQUIRED;
            bad_cnt_d  = 3'd0;
            good_cgs_d = 3'd0;
          end else begin
            state_d = ACQUIRE_SYNC;
          end
        end
        ACQUIRE_SYNC: begin
          if (cgbad) begin
            state_d = LOSS_OF_SYNC;
          end else if (bus.RXCHARISCOMMA) begin
            state_d     = COMMA_DETECT;
            comma_cnt_d = comma_cnt_q + 2'd1;
            rx_even_d   = 1'b1;
          end
        end
        SYNC_ACQUIRED: begin
          if (cgbad) begin
            bad_cnt_d  = bad_inc;
            good_cgs_d = 3'd0;
            if (bad_inc == BAD_N) begin
              state_d = LOSS_OF_SYNC;
              los_evt = 1'b1;
            end
          end else begin
            if (bus.RXCHARISCOMMA) rx_even_d = 1'b1;
            if (bad_cnt_q == 3'd0) begin
              good_cgs_d = 3'd0;
            end else if (good_cgs_q + 3'd1 == GOOD_N) begin
              bad_cnt_d  = bad_cnt_q - 3'd1;
              good_cgs_d = 3'd0;
            end else begin
              good_cgs_d = good_cgs_q + 3'd1;
            end
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end
  end

  always_ff @(posedge RXUSRCLK2) begin
    if (RXRESET) begin
      state_q     <= LOSS_OF_SYNC;
      rx_even_q   <= 1'b0;
      comma_cnt_q <= 2'd0;
      bad_cnt_q   <= 3'd0;
      good_cgs_q  <= 3'd0;
      sync_q      <= 1'b0;
      align_q     <= 1'b1;
      data_q      <= 8'h00;
      k_q         <= 1'b0;
      err_q       <= 1'b0;
      los_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_even_q   <= rx_even_d;
      comma_cnt_q <= comma_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      good_cgs_q  <= good_cgs_d;
      sync_q      <= (state_d == SYNC_ACQUIRED);
      align_q     <= (state_d == LOSS_OF_SYNC);
      data_q      <= bus.RXDATA;
      k_q         <= bus.RXCHARISK;
      err_q       <= invalid;
      if (los_evt && (los_q != '1)) los_q <= los_q + 1'b1;
    end
  end

  // rx_even_q describes the code-group now sitting in data_q, so it doubles as RX_EVEN
  assign bus.SYNC_STATUS   = sync_q;
  assign bus.ENPCOMMAALIGN = align_q;
  assign bus.ENMCOMMAALIGN = align_q;
  assign bus.RX_EVEN       = rx_even_q;
  assign bus.RXDATA_OUT    = data_q;
  assign bus.RXCHARISK_OUT = k_q;
  assign bus.RXERR_OUT     = err_q;
  assign bus.LOS_COUNT     = los_q;

endmodule

// File: tb/tb_pcs_rx_sync_1000x.sv
// Bench for pcs_rx_sync_1000x: a vector table of code-group kinds with
// expected status outputs, applied one per cycle through a scoreboard queue.
module tb_pcs_rx_sync_1000x;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcs_rx_sync_1000x_if #(.LOS_CNT_WIDTH(LW)) bus ();

  pcs_rx_sync_1000x #(.LOS_CNT_WIDTH(LW)) dut (
    .RXUSRCLK2 (clk),
    .RXRESET   (rst),
    .bus       (bus)
  );

  // KC=K28.5 comma, DC=D16.2, ER=disparity error, NT=not-in-table,
  // EI=electrical idle, BE=elastic buffer error, RS=reset
  typedef enum {KC, DC, ER, NT, EI, BE, RS} kind_e;

  typedef struct {
    kind_e          kind;
    logic           sync;
    logic           en;
    logic           even;
    logic [LW-1:0]  los;
  } vec_t;

  typedef struct {
    logic          sync;
    logic          en;
    logic          even;
    logic [7:0]    data;
    logic          k;
    logic          err;
    logic [LW-1:0] los;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(kind_e k, logic s, logic e, logic v, logic [LW-1:0] l);
    vec_t t;
    t.kind = k; t.sync = s; t.en = e; t.even = v; t.los = l;
    tbl.push_back(t);
  endfunction

  // Three comma/data pairs from LOSS_OF_SYNC; sync shows after the last data
  function automatic void acq(logic [LW-1:0] l);
    for (int i = 0; i < 6; i++)
      add((i % 2) ? DC : KC, (i == 5), 1'b0, (i % 2 == 0), l);
  endfunction

  task automatic drive(kind_e k);
    rst               = 1'b0;
    bus.RESETDONE     = 1'b1;
    bus.RXELECIDLE    = 1'b0;
    bus.RXBUFERR      = 1'b0;
    bus.RXDATA        = 8'h50;
    bus.RXCHARISK     = 1'b0;
    bus.RXCHARISCOMMA = 1'b0;
    bus.RXDISPERR     = 1'b0;
    bus.RXNOTINTABLE  = 1'b0;
    case (k)
      KC: begin bus.RXDATA = 8'hBC; bus.RXCHARISK = 1'b1; bus.RXCHARISCOMMA = 1'b1; end
      ER: bus.RXDISPERR    = 1'b1;
      NT: bus.RXNOTINTABLE = 1'b1;
      EI: bus.RXELECIDLE   = 1'b1;
      BE: bus.RXBUFERR     = 1'b1;
      RS: rst              = 1'b1;
      default: ;
    endcase
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] want);
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, n_vec, act, want);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t x;
    drive(v.kind);
    x.sync = v.sync;
    x.en   = v.en;
    x.even = v.even;
    x.data = (v.kind == RS) ? 8'h00 : ((v.kind == KC) ? 8'hBC : 8'h50);
    x.k    = (v.kind == KC);
    x.err  = (v.kind == ER) || (v.kind == NT);
    x.los  = v.los;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    n_vec++;
    chk("SYNC_STATUS",   {7'd0, bus.SYNC_STATUS},   {7'd0, x.sync});
    chk("ENPCOMMAALIGN", {7'd0, bus.ENPCOMMAALIGN}, {7'd0, x.en});
    chk("ENMCOMMAALIGN", {7'd0, bus.ENMCOMMAALIGN}, {7'd0, x.en});
    chk("RX_EVEN",       {7'd0, bus.RX_EVEN},       {7'd0, x.even});
    chk("RXDATA_OUT",    bus.RXDATA_OUT,            x.data);
    chk("RXCHARISK_OUT", {7'd0, bus.RXCHARISK_OUT}, {7'd0, x.k});
    chk("RXERR_OUT",     {7'd0, bus.RXERR_OUT},     {7'd0, x.err});
    chk("LOS_COUNT",     8'(bus.LOS_COUNT),         8'(x.los));
  endtask

  initial begin
    vec_t v;

    add(RS, 0, 1, 0, 0); add(RS, 0, 1, 0, 0);
    acq(0);
    add(KC, 1, 0, 1, 0); add(DC, 1, 0, 0, 0);
    // three bads, then twelve goods cancel them all
    add(ER, 1, 0, 1, 0); add(ER, 1, 0, 0, 0); add(ER, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) add((i % 2) ? KC : DC, 1, 0, (i % 2), 0);
    // four bads from a clean count lose sync on the fourth
    add(NT, 1, 0, 0, 0); add(NT, 1, 0, 1, 0); add(NT, 1, 0, 0, 0); add(NT, 0, 1, 1, 1);
    // odd-position comma while acquiring
    add(KC, 0, 0, 1, 1); add(DC, 0, 0, 0, 1); add(KC, 0, 0, 1, 1); add(DC, 0, 0, 0, 1);
    add(DC, 0, 0, 1, 1); add(KC, 0, 1, 0, 1);
    // comma followed by a non-data code-group
    add(KC, 0, 0, 1, 1); add(KC, 0, 1, 0, 1);
    acq(1);
    add(KC, 1, 0, 1, 1); add(DC, 1, 0, 0, 1); add(EI, 0, 1, 0, 2);
    acq(2);
    add(KC, 1, 0, 1, 2); add(BE, 0, 1, 0, 3);
    acq(3);
    add(EI, 0, 1, 0, 3);
    acq(3);
    add(RS, 0, 1, 0, 0); add(RS, 0, 1, 0, 0);
    acq(0);
    // a bad on the would-be recovery cycle counts as bad, no decrement
    add(ER, 1, 0, 1, 0); add(DC, 1, 0, 0, 0); add(KC, 1, 0, 1, 0); add(DC, 1, 0, 0, 0);
    add(ER, 1, 0, 1, 0); add(ER, 1, 0, 0, 0); add(ER, 0, 1, 1, 1);

    foreach (tbl[i]) apply(tbl[i]);

    // Hand sequence: re-acquire and stream /I2/; each BC must be marked even
    for (int i = 0; i < 16; i++) begin
      v.kind = (i % 2) ? DC : KC;
      v.sync = (i >= 5);
      v.en   = 1'b0;
      v.even = (i % 2 == 0);
      v.los  = 1;
      apply(v);
    end

    // Hand sequence: reset held for one cycle mid-sync then released into idle
    v.kind = RS; v.sync = 0; v.en = 1; v.even = 0; v.los = 0;
    apply(v);
    v.kind = DC; v.sync = 0; v.en = 1; v.even = 1; v.los = 0;
    apply(v);
    v.kind = DC; v.sync = 0; v.en = 1; v.even = 0; v.los = 0;
    apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
